// File: rtl/mips_stage_writeback_pkg.sv
// Shared MIPS pipeline types: word/register widths, load encodings, MEM/WB and WB-forward bundles.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package mips_stage_writeback_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [WORD_W-1:0]     Mips_Type_Word;
    typedef logic [REG_ADDR_W-1:0] Mips_Type_RegAddr;

    // Load access size. Signedness is carried separately in the control bundle.
    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_B = 2'd1,
        LOAD_H = 2'd2
    } Mips_Type_LoadSize;

    typedef struct packed {
        logic Clock;
        logic Reset;
    } Data_Control_Control_T;

    typedef struct packed {
        logic              regWrite;
        logic              memToReg;
        Mips_Type_LoadSize loadSize;
        logic              loadSigned;
    } Mips_Pipeline_Control_T;

    typedef struct packed {
        Mips_Type_RegAddr readAddrA;
        Mips_Type_RegAddr readAddrB;
        Mips_Type_RegAddr writeAddr;
    } Mips_Pipeline_RegPorts_T;

    typedef struct packed {
        Mips_Type_Word           instruction;
        Mips_Type_Word           pcAddr;
        Mips_Type_Word           memOut;
        Mips_Type_Word           aluResult;
        Mips_Pipeline_RegPorts_T regPorts;
        Mips_Pipeline_Control_T  control;
        logic                    valid;
    } Mips_Pipeline_MemReg_T;

    localparam int MemReg_W = $bits(Mips_Pipeline_MemReg_T);

    typedef struct packed {
        logic             valid;
        Mips_Type_RegAddr addr;
        Mips_Type_Word    data;
    } Mips_Pipeline_WbFwd_T;

    localparam int WbFwd_W = $bits(Mips_Pipeline_WbFwd_T);

    function automatic logic [WbFwd_W-1:0] wbfwd_pack(input Mips_Pipeline_WbFwd_T f);
        return f;
    endfunction

    function automatic Mips_Pipeline_WbFwd_T wbfwd_unpack(input logic [WbFwd_W-1:0] v);
        return v;
    endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Sub-word load lane select with sign/zero extension, plus misaligned-access flag.
// Latency: purely combinational.
// Backpressure: none; result tracks inputs.
// Ports: mem_word/off/load_size/load_signed/is_load in; load_val, misaligned out.
module mips_load_extract
    import mips_stage_writeback_pkg::*;
(
    input  Mips_Type_Word     mem_word,
    input  logic [1:0]        off,
    input  Mips_Type_LoadSize load_size,
    input  logic              load_signed,
    input  logic              is_load,
    output Mips_Type_Word     load_val,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Little-endian: byte lane off sits at bits [8*off +: 8]; half lane picked by off[1].
        byte_sel = mem_word[{off, 3'b000} +: 8];
        half_sel = mem_word[{off[1], 4'b0000} +: 16];

        load_val = mem_word;
        case (load_size)
            LOAD_B:  load_val = {{24{load_signed & byte_sel[7]}}, byte_sel};
            LOAD_H:  load_val = {{16{load_signed & half_sel[15]}}, half_sel};
            default: load_val = mem_word;
        endcase

        misaligned = 1'b0;
        if (is_load) begin
            if (load_size == LOAD_H) misaligned = off[0];
            if (load_size == LOAD_W) misaligned = (off != 2'b00);
        end
    end

endmodule

// File: rtl/mips_stage_writeback.sv
// MIPS WB stage: result select, register-file write, WB forward, last-write history, counters, fault.
// Latency: DELAYED=1 one cycle from pipeMemReg to write port; DELAYED=0 combinational.
// Backpressure: stall holds the WB register and suppresses the write/retire for that cycle.
// Ports: ctrl (Clock/Reset), pipeMemReg, stall in; regWrite*, pipeWbFwd, hist*, retired, cycles, fault, faultPc out.
module mips_stage_writeback
    import mips_stage_writeback_pkg::*;
#(
    parameter bit DELAYED     = 1'b1,
    parameter int CNT_W       = 32,
    parameter bit INVERT_CTRL = 1'b0
) (
    input  Data_Control_Control_T ctrl,
    input  logic [MemReg_W-1:0]   pipeMemReg,
    input  logic                  stall,
    output logic                  regWriteEn,
    output logic [4:0]            regWriteAddr,
    output logic [31:0]           regWriteData,
    output logic [WbFwd_W-1:0]    pipeWbFwd,
    output logic                  histValid,
    output logic [4:0]            histAddr,
    output logic [31:0]           histData,
    output logic [CNT_W-1:0]      retired,
    output logic [CNT_W-1:0]      cycles,
    output logic                  fault,
    output logic [31:0]           faultPc
);

    logic clk;
    logic rst_n;
    assign clk   = ctrl.Clock;
    assign rst_n = ctrl.Reset;

    Mips_Pipeline_MemReg_T mr_in;
    Mips_Pipeline_MemReg_T wb;
    logic                  hold;

    assign mr_in = pipeMemReg;

    generate
        if (DELAYED) begin : g_reg
            Mips_Pipeline_MemReg_T wb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wb_q <= '0;
                end else if (!stall) begin
                    wb_q <= mr_in;
                end
            end
            assign wb   = wb_q;
            assign hold = stall;
        end else begin : g_comb
            assign wb   = mr_in;
            assign hold = 1'b0;
        end
    endgenerate

    // Polarity-normalised control bits.
    logic reg_write;
    logic mem_to_reg;
    assign reg_write  = wb.control.regWrite ^ INVERT_CTRL;
    assign mem_to_reg = wb.control.memToReg ^ INVERT_CTRL;

    Mips_Type_Word load_val;
    logic          misaligned;

    mips_load_extract u_load_extract (
        .mem_word    (wb.memOut),
        .off         (wb.aluResult[1:0]),
        .load_size   (wb.control.loadSize),
        .load_signed (wb.control.loadSigned),
        .is_load     (mem_to_reg),
        .load_val    (load_val),
        .misaligned  (misaligned)
    );

    // rst_n gating keeps the write port quiet during reset even in pass-through mode.
    logic advance;
    assign advance = wb.valid & ~hold & rst_n;

    Mips_Type_Word result;
    assign result = mem_to_reg ? load_val : wb.aluResult;

    assign regWriteEn   = advance & ~misaligned & reg_write & (wb.regPorts.writeAddr != 5'd0);
    assign regWriteAddr = rst_n ? wb.regPorts.writeAddr : 5'd0;
    assign regWriteData = rst_n ? result : 32'd0;

    Mips_Pipeline_WbFwd_T fwd;
    always_comb begin
        fwd       = '0;
        fwd.valid = regWriteEn;
        fwd.addr  = regWriteAddr;
        fwd.data  = regWriteData;
    end
    assign pipeWbFwd = wbfwd_pack(fwd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            histValid <= 1'b0;
            histAddr  <= '0;
            histData  <= '0;
            retired   <= '0;
            cycles    <= '0;
            fault     <= 1'b0;
            faultPc   <= '0;
        end else begin
            cycles    <= cycles + CNT_W'(1);
            histValid <= regWriteEn;
            if (regWriteEn) begin
                histAddr <= regWriteAddr;
                histData <= regWriteData;
            end
            // Non-writing instructions (stores, branches, $0 targets) still retire.
            if (advance && !misaligned) begin
                retired <= retired + CNT_W'(1);
            end
            if (advance && misaligned) begin
                fault <= 1'b1;
                if (!fault) begin
                    faultPc <= wb.pcAddr;
                end
            end
        end
    end

    // Fields carried by the bundle for other stages; not consumed here.
    logic unused_fields;
    assign unused_fields = ^{wb.instruction, wb.regPorts.readAddrA, wb.regPorts.readAddrB};

endmodule

// File: tb/tb_mips_stage_writeback.sv
module tb_mips_stage_writeback;
    import mips_stage_writeback_pkg::*;

    localparam int CNT_W = 32;

    logic clk;
    logic rst_n;
    logic stall;
    Data_Control_Control_T ctrl;
    Mips_Pipeline_MemReg_T mr;

    logic               regWriteEn;
    logic [4:0]         regWriteAddr;
    logic [31:0]        regWriteData;
    logic [WbFwd_W-1:0] pipeWbFwd;
    logic               histValid;
    logic [4:0]         histAddr;
    logic [31:0]        histData;
    logic [CNT_W-1:0]   retired;
    logic [CNT_W-1:0]   cycles;
    logic               fault;
    logic [31:0]        faultPc;

    Mips_Pipeline_WbFwd_T fwd;
    assign fwd = wbfwd_unpack(pipeWbFwd);

    assign ctrl = '{Clock: clk, Reset: rst_n};

    mips_stage_writeback #(.DELAYED(1'b1), .CNT_W(CNT_W), .INVERT_CTRL(1'b0)) dut (
        .ctrl         (ctrl),
        .pipeMemReg   (mr),
        .stall        (stall),
        .regWriteEn   (regWriteEn),
        .regWriteAddr (regWriteAddr),
        .regWriteData (regWriteData),
        .pipeWbFwd    (pipeWbFwd),
        .histValid    (histValid),
        .histAddr     (histAddr),
        .histData     (histData),
        .retired      (retired),
        .cycles       (cycles),
        .fault        (fault),
        .faultPc      (faultPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cyc  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input logic rw, input logic m2r, input Mips_Type_LoadSize sz,
                       input logic sg, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc);
        mr                     = '0;
        mr.valid               = v;
        mr.control.regWrite    = rw;
        mr.control.memToReg    = m2r;
        mr.control.loadSize    = sz;
        mr.control.loadSigned  = sg;
        mr.regPorts.writeAddr  = wa;
        mr.aluResult           = alu;
        mr.memOut              = mem;
        mr.pcAddr              = pc;
        mr.instruction         = 32'hDEAD_0000 | {16'd0, pc[15:0]};
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, LOAD_W, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        exp_cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        mr    = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_en",      {63'd0, regWriteEn}, 64'd0);
        check("rst_wdata",   {32'd0, regWriteData}, 64'd0);
        check("rst_hist",    {26'd0, histValid, histAddr, histData}, 64'd0);
        check("rst_cnt",     {retired, cycles}, 64'd0);
        check("rst_fault",   {31'd0, fault, faultPc}, 64'd0);

        rst_n = 1'b1;
        exp_cyc = 0;

        // lbu, off=3
        put(1'b1, 1'b1, 1'b1, LOAD_B, 1'b0, 5'd5, 32'h0000_0103, 32'h80FF_1234, 32'h100);
        step();
        check("lbu_en",    {63'd0, regWriteEn}, 64'd1);
        check("lbu_addr",  {59'd0, regWriteAddr}, 64'd5);
        check("lbu_data",  {32'd0, regWriteData}, 64'h0000_0080);
        check("lbu_fwd",   {26'd0, fwd.valid, fwd.addr, fwd.data}, {26'd0, 1'b1, 5'd5, 32'h0000_0080});
        check("lbu_ret",   retired, 64'd0);

        // lb, same stimulus
        put(1'b1, 1'b1, 1'b1, LOAD_B, 1'b1, 5'd5, 32'h0000_0103, 32'h80FF_1234, 32'h104);
        step();
        check("lb_data",   {32'd0, regWriteData}, 64'hFFFF_FF80);
        check("lb_en",     {63'd0, regWriteEn}, 64'd1);
        check("lb_hist",   {26'd0, histValid, histAddr, histData}, {26'd0, 1'b1, 5'd5, 32'h0000_0080});
        check("lb_ret",    retired, 64'd1);

        // lh, off=2
        put(1'b1, 1'b1, 1'b1, LOAD_H, 1'b1, 5'd6, 32'h0000_0202, 32'h8001_5678, 32'h108);
        step();
        check("lh_data",   {32'd0, regWriteData}, 64'hFFFF_8001);
        check("lh_ret",    retired, 64'd2);

        // lh, off=1 -> misaligned
        put(1'b1, 1'b1, 1'b1, LOAD_H, 1'b1, 5'd8, 32'h0000_0301, 32'h1111_2222, 32'h200);
        step();
        check("mis_en",    {63'd0, regWriteEn}, 64'd0);
        check("mis_fwdv",  {63'd0, fwd.valid}, 64'd0);
        check("mis_ret",   retired, 64'd3);
        check("mis_hist",  {26'd0, histValid, histAddr, histData}, {26'd0, 1'b1, 5'd6, 32'hFFFF_8001});

        // second misaligned load: lw off=2
        put(1'b1, 1'b1, 1'b1, LOAD_W, 1'b0, 5'd9, 32'h0000_0402, 32'h3333_4444, 32'h300);
        step();
        check("f1_fault",  {63'd0, fault}, 64'd1);
        check("f1_pc",     {32'd0, faultPc}, 64'h200);
        check("f1_ret",    retired, 64'd3);
        check("f1_hv",     {63'd0, histValid}, 64'd0);
        check("lw_mis_en", {63'd0, regWriteEn}, 64'd0);

        // ALU op writing $0
        put(1'b1, 1'b1, 1'b0, LOAD_W, 1'b0, 5'd0, 32'h0000_1234, 32'h0, 32'h304);
        step();
        check("r0_en",     {63'd0, regWriteEn}, 64'd0);
        check("f2_pc",     {32'd0, faultPc}, 64'h200);
        check("f2_fault",  {63'd0, fault}, 64'd1);
        check("f2_ret",    retired, 64'd3);

        // add $7 = 0x55, then stall two cycles
        put(1'b1, 1'b1, 1'b0, LOAD_W, 1'b0, 5'd7, 32'h0000_0055, 32'h0, 32'h308);
        step();
        check("r0_ret",    retired, 64'd4);
        check("r0_hv",     {63'd0, histValid}, 64'd0);
        check("add_en",    {63'd0, regWriteEn}, 64'd1);
        stall = 1'b1;
        idle();
        #1;
        check("stl_en0",   {63'd0, regWriteEn}, 64'd0);
        step();
        check("stl_en1",   {63'd0, regWriteEn}, 64'd0);
        check("stl_ret1",  retired, 64'd4);
        step();
        check("stl_en2",   {63'd0, regWriteEn}, 64'd0);
        check("stl_ret2",  retired, 64'd4);
        check("stl_hv",    {63'd0, histValid}, 64'd0);
        stall = 1'b0;
        #1;
        check("add_wr",    {26'd0, regWriteEn, regWriteAddr, regWriteData}, {26'd0, 1'b1, 5'd7, 32'h55});
        step();
        check("add_hist",  {26'd0, histValid, histAddr, histData}, {26'd0, 1'b1, 5'd7, 32'h55});
        check("add_ret",   retired, 64'd5);
        check("add_after", {63'd0, regWriteEn}, 64'd0);
        check("cyc_run",   cycles, exp_cyc);

        // pending write, then async reset mid-cycle
        put(1'b1, 1'b1, 1'b0, LOAD_W, 1'b0, 5'd9, 32'h0000_0077, 32'h0, 32'h30C);
        step();
        check("pend_en",   {63'd0, regWriteEn}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_en",   {63'd0, regWriteEn}, 64'd0);
        check("arst_wr",   {27'd0, regWriteAddr, regWriteData}, 64'd0);
        check("arst_cnt",  {retired, cycles}, 64'd0);
        check("arst_flt",  {31'd0, fault, faultPc}, 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        exp_cyc = 0;
        step();
        check("post_hist", {26'd0, histValid, histAddr, histData}, 64'd0);
        check("post_flt",  {31'd0, fault, faultPc}, 64'd0);
        check("post_ret",  retired, 64'd0);
        check("post_cyc",  cycles, exp_cyc);

        // cycle counter wrap
        force dut.cycles = '1;
        #4;
        release dut.cycles;
        @(posedge clk);
        @(negedge clk);
        check("wrap_cyc",  cycles, 64'd0);
        check("wrap_ret",  retired, 64'd0);
        check("wrap_flt",  {31'd0, fault, faultPc}, 64'd0);
        check("wrap_en",   {63'd0, regWriteEn}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
